rpn_stack_alu: RTL and testbench

Parametrised stack-based RPN arithmetic unit, the next generation of the team's 16-bit stack calculator. Operands are pushed onto a hardware stack. Operations consume the top entries and push their result. The top two entries live in registers; deeper entries live in a synchronous-read RAM. Compared with the previous generation, this block adds configurable width and depth, SUB/logic/DUP/CLR operations, a 2-cycle PICK with a busy flag, and sticky overflow/underflow/illegal-op error flags with a guaranteed no-side-effect rule on error.

---
 rtl/rpn_stack_alu_if.sv | 29 ++
 rtl/rpn_stack_alu.sv | 195 +++++++++++++++++++
 tb/tb_rpn_stack_alu.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/rpn_stack_alu_if.sv
// Command/status bundle for the RPN stack ALU.
// The master drives commands; the slave (the ALU) reports stack state and error flags.
interface rpn_stack_alu_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 1024
) ();
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             en;
  logic             push;
  logic [WIDTH-1:0] d;
  logic [3:0]       op;
  logic [WIDTH-1:0] out;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic             err_ovf;
  logic             err_udf;
  logic             err_ill;

  modport master (
    output en, push, d, op,
    input  out, cnt, busy, err_ovf, err_udf, err_ill
  );

  modport slave (
    input  en, push, d, op,
    output out, cnt, busy, err_ovf, err_udf, err_ill
  );
endinterface

// File: rtl/rpn_stack_alu.sv
// Stack-based RPN ALU: T and S live in registers, deeper entries in a synchronous-read RAM
// whose read port always holds the third entry so that pops refill S with no bubble.
module rpn_stack_alu #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 1024
) (
  input logic            clk,
  input logic            nrst,
  rpn_stack_alu_if.slave bus_io
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned XW = ((WIDTH > CW) ? WIDTH : CW) + 1;

  typedef enum logic [3:0] {
    OpSgn  = 4'd0,  OpNeg  = 4'd1,  OpAdd  = 4'd2,  OpMul  = 4'd3,
    OpSwap = 4'd4,  OpPick = 4'd5,  OpDrop = 4'd6,  OpDrp2 = 4'd7,
    OpSub  = 4'd8,  OpDup  = 4'd9,  OpAnd  = 4'd10, OpOr   = 4'd11,
    OpXor  = 4'd12, OpClr  = 4'd13, OpIll0 = 4'd14, OpIll1 = 4'd15
  } op_e;

  typedef enum logic {StIdle, StPick} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] t_q, t_d, s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d, udf_q, udf_d, ill_q, ill_d;
  logic             pick_n0_q, pick_n0_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic             we;
  logic [AW-1:0]    waddr, raddr;
  logic             pick_go;

  logic             has1, has2, full, pick_ok, sgn_pos;
  logic [XW-1:0]    n_x, lim_x, pick_pos;
  logic [WIDTH-1:0] alu_res;

  assign has1    = (cnt_q != '0);
  assign has2    = (cnt_q >= CW'(2));
  assign full    = (cnt_q == CW'(DEPTH));
  assign n_x     = XW'(t_q);
  assign lim_x   = XW'(cnt_q) - XW'(2);
  assign pick_ok = has2 && (n_x <= lim_x);
  // Stack position counted from the bottom of the entry n below T.
  assign pick_pos = lim_x - n_x;
  assign sgn_pos  = !t_q[WIDTH-1] && (t_q != '0);
  // Only a push/DUP spills S into RAM, always to the slot just above the old third entry.
  assign waddr    = AW'(cnt_q - CW'(2));

  always_comb begin
    alu_res = '0;
    case (op_e'(bus_io.op))
      OpAdd:   alu_res = s_q + t_q;
      OpMul:   alu_res = s_q * t_q;
      OpSub:   alu_res = s_q - t_q;
      OpAnd:   alu_res = s_q & t_q;
      OpOr:    alu_res = s_q | t_q;
      OpXor:   alu_res = s_q ^ t_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    t_d       = t_q;
    s_d       = s_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    ill_d     = ill_q;
    state_d   = state_q;
    pick_n0_d = pick_n0_q;
    we        = 1'b0;
    pick_go   = 1'b0;

    if (state_q == StPick) begin
      t_d     = pick_n0_q ? s_q : rdata_q;
      state_d = StIdle;
    end else if (bus_io.en) begin
      if (bus_io.push) begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          t_d   = bus_io.d;
          s_d   = t_q;
          cnt_d = cnt_q + CW'(1);
          we    = has2;
        end
      end else begin
        unique case (op_e'(bus_io.op))
          OpSgn: begin
            if (has1) t_d = {{(WIDTH-1){1'b0}}, sgn_pos};
            else      udf_d = 1'b1;
          end
          OpNeg: begin
            if (has1) t_d = '0 - t_q;
            else      udf_d = 1'b1;
          end
          OpAdd, OpMul, OpSub, OpAnd, OpOr, OpXor: begin
            if (has2) begin
              t_d   = alu_res;
              s_d   = rdata_q;
              cnt_d = cnt_q - CW'(1);
            end else begin
              udf_d = 1'b1;
            end
          end
          OpSwap: begin
            if (has2) begin
              t_d = s_q;
              s_d = t_q;
            end else begin
              udf_d = 1'b1;
            end
          end
          OpPick: begin
            if (pick_ok) begin
              state_d   = StPick;
              pick_n0_d = (t_q == '0);
              pick_go   = 1'b1;
            end else begin
              udf_d = 1'b1;
            end
          end
          OpDrop, OpDrp2: begin
            if (has1) begin
              t_d   = s_q;
              s_d   = rdata_q;
              cnt_d = cnt_q - CW'(1);
            end else begin
              udf_d = 1'b1;
            end
          end
          OpDup: begin
            if (!has1) begin
              udf_d = 1'b1;
            end else if (full) begin
              ovf_d = 1'b1;
            end else begin
              s_d   = t_q;
              cnt_d = cnt_q + CW'(1);
              we    = has2;
            end
          end
          OpClr: begin
            cnt_d = '0;
            ovf_d = 1'b0;
            udf_d = 1'b0;
            ill_d = 1'b0;
          end
          OpIll0, OpIll1: ill_d = 1'b1;
        endcase
      end
    end

    // Read the new third entry so it is ready after the edge; a PICK borrows the port once.
    raddr = pick_go ? AW'(pick_pos) : AW'(cnt_d - CW'(3));
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= StIdle;
      t_q       <= '0;
      s_q       <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      ill_q     <= 1'b0;
      pick_n0_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      s_q       <= s_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      ill_q     <= ill_d;
      pick_n0_q <= pick_n0_d;
    end
  end

  // Write-first: a spill to the slot being prefetched is forwarded straight to the read data.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= s_q;
    rdata_q <= (we && (waddr == raddr)) ? s_q : mem_q[raddr];
  end

  assign bus_io.out     = has1 ? t_q : '0;
  assign bus_io.cnt     = cnt_q;
  assign bus_io.busy    = (state_q == StPick);
  assign bus_io.err_ovf = ovf_q;
  assign bus_io.err_udf = udf_q;
  assign bus_io.err_ill = ill_q;
endmodule

// File: tb/tb_rpn_stack_alu.sv
// Directed bench for rpn_stack_alu: a 1024-deep and a 4-deep instance, expected out/cnt
// queued per command and compared one cycle after the accepting edge.
module tb_rpn_stack_alu;
  localparam logic [3:0] OpSgn = 4'd0, OpNeg = 4'd1, OpAdd = 4'd2, OpMul = 4'd3;
  localparam logic [3:0] OpSwap = 4'd4, OpPick = 4'd5, OpDrop = 4'd6, OpSub = 4'd8;
  localparam logic [3:0] OpDup = 4'd9, OpAnd = 4'd10, OpOr = 4'd11, OpXor = 4'd12;
  localparam logic [3:0] OpClr = 4'd13, OpIll = 4'd14;

  typedef struct {
    string       tag;
    logic [15:0] out;
    int unsigned cnt;
  } exp_t;

  logic clk = 1'b0;
  logic nrst;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  rpn_stack_alu_if #(.WIDTH(16), .DEPTH(1024)) ifa ();
  rpn_stack_alu_if #(.WIDTH(16), .DEPTH(4))    ifb ();

  rpn_stack_alu #(.WIDTH(16), .DEPTH(1024)) u_a (.clk(clk), .nrst(nrst), .bus_io(ifa.slave));
  rpn_stack_alu #(.WIDTH(16), .DEPTH(4))    u_b (.clk(clk), .nrst(nrst), .bus_io(ifb.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One command cycle on instance b (0 = deep, 1 = shallow); expectation queued at drive time.
  task automatic cmd(input bit b, input logic p, input logic [15:0] dv, input logic [3:0] o,
                     input string tag, input logic [15:0] eo, input int unsigned ec);
    exp_t        e;
    logic [15:0] oo;
    logic [31:0] oc;
    e.tag = tag;
    e.out = eo;
    e.cnt = ec;
    sb.push_back(e);
    if (!b) begin
      ifa.en = 1'b1; ifa.push = p; ifa.d = dv; ifa.op = o;
    end else begin
      ifb.en = 1'b1; ifb.push = p; ifb.d = dv; ifb.op = o;
    end
    @(posedge clk);
    #1;
    ifa.en = 1'b0;
    ifb.en = 1'b0;
    if (!b) begin
      oo = ifa.out; oc = 32'(ifa.cnt);
    end else begin
      oo = ifb.out; oc = 32'(ifb.cnt);
    end
    e = sb.pop_front();
    chk({e.tag, ".out"}, 32'(oo), 32'(e.out));
    chk({e.tag, ".cnt"}, oc, e.cnt);
  endtask

  task automatic idle();
    ifa.en = 1'b0;
    ifb.en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    nrst = 1'b0;
    ifa.en = 1'b0; ifa.push = 1'b0; ifa.d = '0; ifa.op = '0;
    ifb.en = 1'b0; ifb.push = 1'b0; ifb.d = '0; ifb.op = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst.out", 32'(ifa.out), 0);
    chk("rst.cnt", 32'(ifa.cnt), 0);
    chk("rst.busy", 32'(ifa.busy), 0);
    chk("rst.errs", {29'd0, ifa.err_ovf, ifa.err_udf, ifa.err_ill}, 0);
    nrst = 1'b1;
    idle();

    // Subtract, negate, sign
    cmd(0, 1, 16'd7, OpSgn, "t1.push7", 16'd7, 1);
    cmd(0, 1, 16'd5, OpSgn, "t1.push5", 16'd5, 2);
    cmd(0, 0, 16'd0, OpSub, "t1.sub", 16'd2, 1);
    cmd(0, 0, 16'd0, OpNeg, "t1.neg", 16'hFFFE, 1);
    cmd(0, 0, 16'd0, OpSgn, "t1.sgn_neg", 16'd0, 1);
    cmd(0, 0, 16'd0, OpClr, "t1.clr", 16'd0, 0);

    // Back-to-back pushes and pops with no idle cycles
    cmd(0, 1, 16'd3, OpSgn, "t2.push3", 16'd3, 1);
    cmd(0, 1, 16'd4, OpSgn, "t2.push4", 16'd4, 2);
    cmd(0, 1, 16'd5, OpSgn, "t2.push5", 16'd5, 3);
    cmd(0, 0, 16'd0, OpAdd, "t2.add", 16'd9, 2);
    cmd(0, 0, 16'd0, OpMul, "t2.mul", 16'd27, 1);
    cmd(0, 0, 16'd0, OpClr, "t2.clr", 16'd0, 0);

    // PICK: two cycles, busy ignores commands, failed PICK is side-effect free
    cmd(0, 1, 16'd10, OpSgn, "t3.push10", 16'd10, 1);
    cmd(0, 1, 16'd20, OpSgn, "t3.push20", 16'd20, 2);
    cmd(0, 1, 16'd30, OpSgn, "t3.push30", 16'd30, 3);
    cmd(0, 1, 16'd2, OpSgn, "t3.push2", 16'd2, 4);
    cmd(0, 0, 16'd0, OpPick, "t3.pick_acc", 16'd2, 4);
    chk("t3.busy_hi", 32'(ifa.busy), 1);
    cmd(0, 1, 16'd99, OpSgn, "t3.pick_done", 16'd10, 4);
    chk("t3.busy_lo", 32'(ifa.busy), 0);
    cmd(0, 1, 16'd9, OpSgn, "t3.push9", 16'd9, 5);
    cmd(0, 0, 16'd0, OpPick, "t3.pick_bad", 16'd9, 5);
    chk("t3.bad_busy", 32'(ifa.busy), 0);
    chk("t3.udf", 32'(ifa.err_udf), 1);
    cmd(0, 0, 16'd0, OpDrop, "t3.drop", 16'd10, 4);
    cmd(0, 0, 16'd0, OpClr, "t3.clr", 16'd0, 0);
    chk("t3.clr_udf", 32'(ifa.err_udf), 0);

    // SWAP, DUP, logic ops, push beating a simultaneous op
    cmd(0, 1, 16'd1, OpSgn, "t7.push1", 16'd1, 1);
    cmd(0, 1, 16'd2, OpSgn, "t7.push2", 16'd2, 2);
    cmd(0, 0, 16'd0, OpSwap, "t7.swap", 16'd1, 2);
    cmd(0, 0, 16'd0, OpDrop, "t7.drop", 16'd2, 1);
    cmd(0, 0, 16'd0, OpDup, "t7.dup", 16'd2, 2);
    cmd(0, 0, 16'd0, OpAdd, "t7.add", 16'd4, 1);
    cmd(0, 0, 16'd0, OpSgn, "t7.sgn_pos", 16'd1, 1);
    cmd(0, 1, 16'h00F0, OpClr, "t7.push_vs_clr", 16'h00F0, 2);
    cmd(0, 1, 16'h0F0F, OpSgn, "t7.push0f0f", 16'h0F0F, 3);
    cmd(0, 0, 16'd0, OpOr, "t7.or", 16'h0FFF, 2);
    cmd(0, 1, 16'h0F00, OpSgn, "t7.push0f00", 16'h0F00, 3);
    cmd(0, 0, 16'd0, OpAnd, "t7.and", 16'h0F00, 2);
    cmd(0, 0, 16'd0, OpClr, "t7.clr", 16'd0, 0);

    // Empty-stack errors, illegal op, XOR
    cmd(0, 0, 16'd0, OpDrop, "t5.drop_empty", 16'd0, 0);
    cmd(0, 0, 16'd0, OpAdd, "t5.add_empty", 16'd0, 0);
    cmd(0, 0, 16'd0, OpSgn, "t5.sgn_empty", 16'd0, 0);
    chk("t5.udf", 32'(ifa.err_udf), 1);
    chk("t5.ill_pre", 32'(ifa.err_ill), 0);
    cmd(0, 0, 16'd0, OpIll, "t5.op14", 16'd0, 0);
    chk("t5.ill", 32'(ifa.err_ill), 1);
    cmd(0, 1, 16'h00F0, OpSgn, "t5.push00f0", 16'h00F0, 1);
    cmd(0, 1, 16'h0F0F, OpSgn, "t5.push0f0f", 16'h0F0F, 2);
    cmd(0, 0, 16'd0, OpXor, "t5.xor", 16'h0FFF, 1);
    chk("t5.udf_sticky", 32'(ifa.err_udf), 1);
    cmd(0, 0, 16'd0, OpClr, "t5.clr", 16'd0, 0);

    // Shallow instance: full, overflow, DUP at full, CLR, RAM pops and PICK
    cmd(1, 1, 16'd1, OpSgn, "t4.push1", 16'd1, 1);
    cmd(1, 1, 16'd2, OpSgn, "t4.push2", 16'd2, 2);
    cmd(1, 1, 16'd3, OpSgn, "t4.push3", 16'd3, 3);
    cmd(1, 1, 16'd4, OpSgn, "t4.push4", 16'd4, 4);
    cmd(1, 1, 16'd5, OpSgn, "t4.push5", 16'd4, 4);
    chk("t4.ovf", 32'(ifb.err_ovf), 1);
    cmd(1, 0, 16'd0, OpDup, "t4.dup_full", 16'd4, 4);
    cmd(1, 0, 16'd0, OpDrop, "t4.drop1", 16'd3, 3);
    cmd(1, 0, 16'd0, OpDrop, "t4.drop2", 16'd2, 2);
    cmd(1, 0, 16'd0, OpDrop, "t4.drop3", 16'd1, 1);
    cmd(1, 0, 16'd0, OpClr, "t4.clr", 16'd0, 0);
    chk("t4.ovf_clr", 32'(ifb.err_ovf), 0);
    cmd(1, 1, 16'd5, OpSgn, "t4.push5b", 16'd5, 1);
    cmd(1, 1, 16'd6, OpSgn, "t4.push6", 16'd6, 2);
    cmd(1, 1, 16'd7, OpSgn, "t4.push7", 16'd7, 3);
    cmd(1, 1, 16'd2, OpSgn, "t4.push2b", 16'd2, 4);
    cmd(1, 0, 16'd0, OpPick, "t4.pick", 16'd2, 4);
    idle();
    chk("t4.pick_out", 32'(ifb.out), 5);

    // Deep stack fill and drain with out checked every cycle
    for (int i = 0; i < 1024; i++) begin
      cmd(0, 1, 16'(i), OpSgn, $sformatf("t6.push%0d", i), 16'(i), i + 1);
    end
    cmd(0, 1, 16'hBEEF, OpSgn, "t6.push_full", 16'd1023, 1024);
    chk("t6.ovf", 32'(ifa.err_ovf), 1);
    for (int k = 1; k <= 1023; k++) begin
      cmd(0, 0, 16'd0, OpDrop, $sformatf("t6.drop%0d", k), 16'(1023 - k), 1024 - k);
    end
    cmd(0, 1, 16'd5, OpSgn, "t6.push5", 16'd5, 2);
    cmd(0, 1, 16'd0, OpSgn, "t6.push0", 16'd0, 3);
    cmd(0, 0, 16'd0, OpPick, "t6.pick", 16'd0, 3);
    chk("t6.busy_hi", 32'(ifa.busy), 1);
    #2;
    nrst = 1'b0;
    #1;
    chk("t6.rst_busy", 32'(ifa.busy), 0);
    chk("t6.rst_cnt", 32'(ifa.cnt), 0);
    chk("t6.rst_out", 32'(ifa.out), 0);
    @(posedge clk);
    #3;
    nrst = 1'b1;
    @(posedge clk);
    #1;
    cmd(0, 1, 16'h1234, OpSgn, "t6.after_rst", 16'h1234, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
